bram_sp_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port Gowin BRAM (through bramwrapper_singleport) between NREQ requesters over valid/ready request channels.
- Returns read data to the issuing requester only, after a fixed latency.
- An optional post-reset clear sequencer zero-fills the memory before arbitration is enabled.
- Sits between cores/DMA engines and the memory wrapper; it drives the wrapper's enable/write/block/addr/data_in pins directly.

---
 rtl/bram_sp_arbiter_pkg.sv | 21 ++
 rtl/bram_sp_arbiter_rr_arbiter.sv | 17 +
 rtl/bram_sp_arbiter.sv | 111 +++++++++++
 tb/tb_bram_sp_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sp_arbiter_pkg.sv
// bram_sp_arbiter_pkg: shared types, widths and the round-robin pick function
package bram_sp_arbiter_pkg;
    typedef enum logic {CLEAR, ARB} state_t;
    localparam int ADDR_W = 11;
    localparam int BLOCK_W = 3;
    localparam int MAXREQ = 8;
    typedef struct packed {
        logic found;
        logic [2:0] idx;
    } pick_t;
    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] valid, input logic [2:0] ptr, input int n);
        pick_t p;
        p = '0;
        for (int k = MAXREQ - 1; k >= 0; k--)
            if (k < n && valid[3'((int'(ptr) + k) % n)]) begin
                p.found = 1'b1;
                p.idx = 3'((int'(ptr) + k) % n);
            end
        return p;
    endfunction
endpackage

// File: rtl/bram_sp_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant to the first valid requester at or above ptr
module rr_arbiter
    import bram_sp_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);
    pick_t p;
    always_comb begin
        p = rr_pick(MAXREQ'(valid), 3'(ptr), NREQ);
        grant = p.found ? NREQ'(1) << p.idx : '0;
    end
endmodule

// File: rtl/bram_sp_arbiter.sv
// bram_sp_arbiter: round-robin single-port BRAM sharing with post-reset clear; BRAM_SP_ARBITER_STATS_EN adds stall_count
module bram_sp_arbiter
    import bram_sp_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WIDTH = 8,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CLEAR_DEPTH = 2048,
    parameter int CLEAR_BLOCK = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [BLOCK_W*NREQ-1:0]  req_block,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [WIDTH*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     busy,
    output logic                     mem_enable,
    output logic                     mem_write,
    output logic [BLOCK_W-1:0]       mem_block,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
`ifdef BRAM_SP_ARBITER_STATS_EN
    ,
    output logic [16*NREQ-1:0]       stall_count
`endif
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(CLEAR_DEPTH - 1);
    state_t state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [NREQ-1:0] grant;
    logic hs;
    logic [ADDR_W:0] cnt;
    logic [READ_LATENCY-1:0] tag_rd;
    logic [PW-1:0] tag_id [READ_LATENCY];
    logic [WIDTH-1:0] rdata_q;
    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .valid(req_valid),
        .ptr  (ptr),
        .grant(grant)
    );
    always_comb begin
        req_ready = (state == ARB && !reset) ? grant : '0;
        hs = |req_ready;
        g = '0;
        for (int i = 0; i < NREQ; i++) g = grant[i] ? PW'(i) : g;
        rsp_rdata = (|rsp_valid) ? mem_rdata : rdata_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : ARB;
            busy <= CLEAR_ON_RESET != 0;
            ptr <= '0;
            cnt <= '0;
            mem_enable <= 1'b0;
            mem_write <= 1'b0;
            mem_block <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            tag_rd <= '0;
            rsp_valid <= '0;
            rdata_q <= '0;
        end else begin
            for (int k = READ_LATENCY - 1; k > 0; k--) begin
                tag_rd[k] <= tag_rd[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            tag_rd[0] <= hs && !req_write[g];
            tag_id[0] <= g;
            rsp_valid <= tag_rd[READ_LATENCY-1] ? NREQ'(1) << tag_id[READ_LATENCY-1] : '0;
            rdata_q <= rsp_rdata;
            if (state == CLEAR) begin
                mem_enable <= 1'b1;
                mem_write <= 1'b1;
                mem_block <= BLOCK_W'(CLEAR_BLOCK);
                mem_addr <= cnt[ADDR_W-1:0];
                mem_wdata <= '0;
                cnt <= cnt + 1'b1;
                state <= cnt == LAST ? ARB : CLEAR;
                busy <= cnt != LAST;
            end else begin
                mem_enable <= hs;
                mem_write <= hs && req_write[g];
                if (hs) begin
                    mem_block <= req_block[g*BLOCK_W +: BLOCK_W];
                    mem_addr <= req_addr[g*ADDR_W +: ADDR_W];
                    mem_wdata <= req_wdata[g*WIDTH +: WIDTH];
                    ptr <= int'(g) == NREQ - 1 ? '0 : g + 1'b1;
                end
            end
        end
    end
`ifdef BRAM_SP_ARBITER_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stall
        logic [15:0] sc;
        always_ff @(posedge clk) begin
            if (reset) sc <= '0;
            else if (state == ARB && req_valid[i] && !req_ready[i] && sc != 16'hFFFF) sc <= sc + 16'd1;
        end
        assign stall_count[i*16 +: 16] = sc;
    end
`endif
endmodule

// File: tb/tb_bram_sp_arbiter.sv
// tb_bram_sp_arbiter: randomized traffic against a queue-based reference model plus directed literal checks
module tb_bram_sp_arbiter;
    localparam int N = 2;
    localparam int W = 8;
    localparam int CD = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_write = '0;
    logic [3*N-1:0] req_block = '0;
    logic [11*N-1:0] req_addr = '0;
    logic [W*N-1:0] req_wdata = '0;
    logic [N-1:0] rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic busy, mem_enable, mem_write;
    logic [2:0] mem_block;
    logic [10:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
`ifdef BRAM_SP_ARBITER_STATS_EN
    logic [16*N-1:0] stall_count;
`endif
    int compared = 0;
    int mismatched = 0;
    logic [N-1:0] hs = '0;

    bram_sp_arbiter #(.NREQ(N), .WIDTH(W), .READ_LATENCY(1), .CLEAR_ON_RESET(1),
                      .CLEAR_DEPTH(CD), .CLEAR_BLOCK(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_block(req_block), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .mem_enable(mem_enable), .mem_write(mem_write),
        .mem_block(mem_block), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef BRAM_SP_ARBITER_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_val(input int k);
        return W'(k * 7 + 8'h3C);
    endfunction

    // single-port memory stand-in with one cycle of read latency
    logic [W-1:0] wmem [16384];
    logic filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int k = 0; k < 16384; k++) wmem[k] <= init_val(k);
            filled <= 1'b1;
        end else if (mem_enable) begin
            if (mem_write) wmem[{mem_block, mem_addr}] <= mem_wdata;
            else mem_rdata <= wmem[{mem_block, mem_addr}];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: expected memory contents, pointer and pending responses
    typedef struct {
        int due;
        int id;
        logic [W-1:0] d;
    } rsp_t;
    rsp_t q[$];
    logic [W-1:0] mm [int];
    int cyc = 0;
    bit mv = 0;
    bit arb = 0;
    int clr = 0;
    int ptr = 0;
    logic e_en, e_wr, e_busy;
    logic [2:0] e_blk;
    logic [10:0] e_adr;
    logic [W-1:0] e_wd;
    logic [W-1:0] last_rd;

    always @(negedge clk) begin : model
        int g;
        int key;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [W-1:0] exp_rd;
        rsp_t r;
        cyc++;
        if (mv) begin
            chk("mem_enable", mem_enable, e_en);
            if (e_en) begin
                chk("mem_write", mem_write, e_wr);
                chk("mem_block", mem_block, e_blk);
                chk("mem_addr", mem_addr, e_adr);
                chk("mem_wdata", mem_wdata, e_wd);
            end
            chk("busy", busy, e_busy);
            exp_rv = '0;
            exp_rd = last_rd;
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                exp_rv = N'(1) << r.id;
                exp_rd = r.d;
            end
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            last_rd = exp_rd;
        end
        g = -1;
        if (!reset && mv && arb)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        exp_rdy = g >= 0 ? N'(1) << g : '0;
        if (mv || reset) chk("req_ready", req_ready, exp_rdy);
        if (reset) begin
            mv = 1;
            arb = 0;
            clr = 0;
            ptr = 0;
            q.delete();
            {e_en, e_wr, e_blk, e_adr, e_wd} = '0;
            e_busy = 1;
            last_rd = '0;
        end else if (mv && !arb) begin
            {e_en, e_wr, e_blk, e_adr, e_wd} = {1'b1, 1'b1, 3'd0, 11'(clr), 8'd0};
            mm[clr] = '0;
            clr++;
            arb = clr == CD;
            e_busy = !arb;
        end else if (mv) begin
            e_en = g >= 0;
            e_busy = 0;
            if (g >= 0) begin
                e_wr = req_write[g];
                e_blk = req_block[g*3 +: 3];
                e_adr = req_addr[g*11 +: 11];
                e_wd = req_wdata[g*W +: W];
                key = int'({e_blk, e_adr});
                ptr = (g + 1) % N;
                if (e_wr) mm[key] = e_wd;
                else q.push_back('{cyc + 2, g, mm.exists(key) ? mm[key] : init_val(key)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic settle();
        #1;
        hs = req_valid & req_ready;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [2:0] b, input logic [10:0] a, input logic [W-1:0] d);
        req_write[i] = wr;
        req_block[i*3 +: 3] = b;
        req_addr[i*11 +: 11] = a;
        req_wdata[i*W +: W] = d;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        int n;
        bit done;
        repeat (3) tick();
        chk("rst_busy", busy, 1);
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_req_ready", req_ready, 0);
        reset = 1'b0;
        set_req(0, 1, 0, 11'd5, 8'h11);
        set_req(1, 1, 0, 11'd9, 8'h22);
        settle();
        for (int i = 0; i < CD; i++) begin
            tick();
            settle();
            chk("clr_enable", mem_enable, 1);
            chk("clr_write", mem_write, 1);
            chk("clr_addr", mem_addr, i);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_busy", busy, i != CD - 1);
            chk("clr_ready", req_ready, i == CD - 1 ? 2'b01 : 2'b00);
        end
        tick();
        settle();
        chk("wr_second_ready", req_ready, 2'b10);
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            set_req(0, 0, 0, 11'd5, 8'h00);
            set_req(1, 0, 0, 11'd9, 8'h00);
            settle();
            chk("alt_ready", req_ready, k % 2 == 0 ? 2'b01 : 2'b10);
            chk("alt_rsp_valid", rsp_valid, k < 2 ? 2'b00 : (k % 2 == 0 ? 2'b01 : 2'b10));
            if (k >= 2) chk("alt_rsp_rdata", rsp_rdata, k % 2 == 0 ? 8'h11 : 8'h22);
        end
        tick();
        req_valid = '0;
        set_req(0, 1, 0, 11'd3, 8'hA5);
        settle();
        chk("a5_wr_ready", req_ready, 2'b01);
        tick();
        set_req(1, 0, 0, 11'd3, 8'h00);
        settle();
        chk("a5_rd_ready", req_ready, 2'b10);
        tick();
        settle();
        tick();
        chk("a5_rsp_valid", rsp_valid, 2'b10);
        chk("a5_rsp_rdata", rsp_rdata, 8'hA5);
        settle();
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            set_req(1, 0, 0, 11'd7, 8'h00);
            settle();
            n += int'(req_ready[1]);
        end
        chk("solo_handshakes", n, 5);
        tick();
        set_req(0, 0, 0, 11'd7, 8'h00);
        set_req(1, 0, 0, 11'd7, 8'h00);
        settle();
        chk("solo_ptr_wrap", req_ready, 2'b01);
        tick();
        reset = 1'b1;
        req_valid = '0;
        settle();
        tick();
        reset = 1'b0;
        chk("rr_rsp_dropped", rsp_valid, 0);
        chk("rr_busy", busy, 1);
        chk("rr_mem_enable", mem_enable, 0);
        settle();
        tick();
        chk("rr_clear_addr0", mem_addr, 0);
        chk("rr_clear_enable", mem_enable, 1);
        chk("rr_rsp_still_dropped", rsp_valid, 0);
        settle();
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            settle();
            done = !busy;
        end
        chk("rr_clear_done", done, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            set_req(0, 0, 1, 11'd1, 8'h00);
            set_req(1, 0, 1, 11'd2, 8'h00);
            settle();
        end
        tick();
        req_valid = '0;
`ifdef BRAM_SP_ARBITER_STATS_EN
        chk("stall0", stall_count[15:0], 5);
        chk("stall1", stall_count[31:16], 5);
`endif
        settle();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                            11'($urandom_range(0, 31)), W'($urandom));
            settle();
        end
        tick();
        reset = 1'b0;
        req_valid = '0;
        settle();
        repeat (4) tick();
        chk("drain_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
